inst_fetch_unit: RTL

Parametrised, pipelined instruction-fetch front end for the MIPS CPU. It replaces single-cycle PC sequencing with a fetch-PC register, a credit-limited request stream to an instruction memory of variable latency, and an in-order prefetch queue feeding decode through a valid/ready handshake. It sits between the instruction memory port and the decode stage. Decode or execute redirects it (jump, jr, taken branch), which flushes queued and in-flight fetches.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/inst_fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned ALIGN_BITS = 2;
  localparam logic [ALIGN_BITS-1:0] ALIGN_MASK = {ALIGN_BITS{1'b1}};

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_en_s;
  logic             pop_en_s;

  assign push_en_s = push & (count_r != CW'(DEPTH));
  assign pop_en_s  = pop & (count_r != CW'(0));
  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy; flush drops contents but leaves stale data in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_en_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + CW'(push_en_s) - CW'(pop_en_s);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Pipelined instruction fetch: credit-limited memory requests, in-order
// prefetch queue towards decode, redirect flush with stale-response discard.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              cpu_rst_n,
  input  logic              cpu_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  localparam int CW = cnt_w(QUEUE_DEPTH);

  logic [ADDR_W-1:0]        fetch_pc_r;
  logic [ADDR_W-1:0]        fetch_pc_nxt_s;
  logic [CW-1:0]            discard_cnt_r;
  logic [CW-1:0]            discard_nxt_s;
  logic [CW-1:0]            outstanding_s;
  logic [CW-1:0]            q_count_s;
  logic [CW:0]              credit_sum_s;
  logic [ADDR_W-1:0]        pcf_head_s;
  logic [ADDR_W+DATA_W-1:0] q_head_s;
  logic                     redirect_s;
  logic                     grant_s;
  logic                     rsp_s;
  logic                     drop_s;
  logic                     keep_s;
  logic                     pop_s;

  // The in-flight PC FIFO occupancy is exactly the outstanding-request count.
  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(QUEUE_DEPTH)) u_inflight_pc (
    .clk       (clk),
    .rst_n     (cpu_rst_n),
    .flush     (1'b0),
    .push      (grant_s),
    .push_data (fetch_pc_r),
    .pop       (rsp_s),
    .pop_data  (pcf_head_s),
    .count     (outstanding_s)
  );

  sync_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(QUEUE_DEPTH)) u_prefetch_q (
    .clk       (clk),
    .rst_n     (cpu_rst_n),
    .flush     (redirect_s),
    .push      (keep_s),
    .push_data ({pcf_head_s, imem_rsp_data}),
    .pop       (pop_s),
    .pop_data  (q_head_s),
    .count     (q_count_s)
  );

  assign redirect_s   = redirect & cpu_en;
  assign credit_sum_s = {1'b0, q_count_s} + {1'b0, outstanding_s} - {1'b0, discard_cnt_r};
  // After a redirect the in-flight FIFO can be full while credit looks free.
  assign imem_req     = cpu_rst_n & cpu_en & ~redirect
                        & (credit_sum_s < (CW+1)'(QUEUE_DEPTH))
                        & (outstanding_s != CW'(QUEUE_DEPTH));
  assign imem_addr    = fetch_pc_r;
  assign grant_s      = imem_req & imem_gnt;
  assign rsp_s        = imem_rsp_valid & (outstanding_s != CW'(0));
  assign drop_s       = rsp_s & (discard_cnt_r != CW'(0));
  assign keep_s       = rsp_s & (discard_cnt_r == CW'(0));
  assign out_valid    = cpu_en & (q_count_s != CW'(0));
  assign pop_s        = out_valid & out_ready;
  assign out_pc       = q_head_s[ADDR_W+DATA_W-1:DATA_W];
  assign out_inst     = q_head_s[DATA_W-1:0];

  // Next fetch address: redirect target (word aligned) or sequential step on grant.
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    if (redirect_s) begin
      fetch_pc_nxt_s = redirect_pc & ~ADDR_W'(ALIGN_MASK);
    end else if (grant_s) begin
      fetch_pc_nxt_s = fetch_pc_r + ADDR_W'(PC_STEP);
    end else begin
      fetch_pc_nxt_s = fetch_pc_r;
    end
  end

  // Discard count: on redirect every request still in flight after this cycle's response goes stale.
  always_comb begin
    discard_nxt_s = discard_cnt_r;
    if (redirect_s) begin
      discard_nxt_s = outstanding_s - CW'(rsp_s);
    end else if (drop_s) begin
      discard_nxt_s = discard_cnt_r - CW'(1);
    end else begin
      discard_nxt_s = discard_cnt_r;
    end
  end

  // Fetch PC and discard counter registers.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      fetch_pc_r    <= RESET_PC;
      discard_cnt_r <= {CW{1'b0}};
    end else begin
      fetch_pc_r    <= fetch_pc_nxt_s;
      discard_cnt_r <= discard_nxt_s;
    end
  end

endmodule
